// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// alu_issue : issue/writeback stage driving an external 32-bit ALU from an
//             8x32 regfile. Optional macro ALU_ISSUE_BACK2BACK_EN (WB->EXEC).
// Revision  : 1.0
// ============================================================================
module alu_issue #(
   parameter int NREGS = 8,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [2:0]    in_op,
   input  logic [2:0]    in_rd,
   input  logic [2:0]    in_rs1,
   input  logic [2:0]    in_rs2,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   output logic [2:0]    alu_f,
   input  logic [DW-1:0] alu_result,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [2:0]    out_rd,
   input  logic [2:0]    dbg_addr,
   output logic [DW-1:0] dbg_data
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_WB   = 2'd2
   } state_t;

   state_t        state_q;
   logic [DW-1:0] rf_q [NREGS];
   logic [2:0]    op_q;
   logic [2:0]    rd_q;
   logic [DW-1:0] a_q;
   logic [DW-1:0] b_q;
   logic [DW-1:0] res_q;

   logic          w_accept;
   logic [DW-1:0] w_rs1_val;
   logic [DW-1:0] w_rs2_val;

   // r0 is never written, but reads are still forced to zero for clarity
   assign w_rs1_val = (in_rs1 == 3'd0)   ? '0 : rf_q[in_rs1];
   assign w_rs2_val = (in_rs2 == 3'd0)   ? '0 : rf_q[in_rs2];
   assign dbg_data  = (dbg_addr == 3'd0) ? '0 : rf_q[dbg_addr];

`ifdef ALU_ISSUE_BACK2BACK_EN
   assign in_ready = (state_q == S_IDLE) || ((state_q == S_WB) && out_ready);
`else
   assign in_ready = (state_q == S_IDLE);
`endif

   assign w_accept  = in_valid && in_ready;
   assign out_valid = (state_q == S_WB);
   assign out_data  = res_q;
   assign out_rd    = rd_q;
   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign alu_f     = op_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         rd_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         for (int i = 0; i < NREGS; i++) begin
            rf_q[i] <= '0;
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               if (w_accept) begin
                  op_q    <= in_op;
                  rd_q    <= in_rd;
                  a_q     <= w_rs1_val;
                  b_q     <= w_rs2_val;
                  state_q <= S_EXEC;
               end
            end
            S_EXEC: begin
               res_q <= alu_result;
               if (rd_q != 3'd0) begin
                  rf_q[rd_q] <= alu_result;
               end
               state_q <= S_WB;
            end
            S_WB: begin
               // w_accept can only be high here in the back-to-back build
               if (out_ready) begin
                  if (w_accept) begin
                     op_q    <= in_op;
                     rd_q    <= in_rd;
                     a_q     <= w_rs1_val;
                     b_q     <= w_rs2_val;
                     state_q <= S_EXEC;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
// tb_alu_issue : directed bench with a transaction-level model of alu_issue.
// Revision     : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_alu_issue;

`ifdef ALU_ISSUE_BACK2BACK_EN
   localparam bit B2B     = 1'b1;
   localparam int SPACING = 2;
`else
   localparam bit B2B     = 1'b0;
   localparam int SPACING = 3;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op, in_rd, in_rs1, in_rs2;
   logic [31:0] alu_a, alu_b;
   logic [2:0]  alu_f;
   logic [31:0] alu_result;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [2:0]  out_rd;
   logic [2:0]  dbg_addr;
   logic [31:0] dbg_data;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct {
      logic [31:0] data;
      logic [2:0]  rd;
      int          acc;
      int          cyc;
   } ent_t;

   ent_t        mq[$];
   ent_t        seen[$];
   logic [31:0] mregs[8];

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_ref(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [63:0] p;
      p = {32'd0, a} * {32'd0, b};
      case (f)
         3'b000:  return a + b;
         3'b001:  return a + 32'd1;
         3'b010:  return a - b;
         3'b011:  return a - 32'd1;
         3'b100:  return p[31:0];
         default: return 32'd0;
      endcase
   endfunction

   // Stand-in for the external combinational ALU
   assign alu_result = alu_ref(alu_f, alu_a, alu_b);

   alu_issue #(.NREGS(8), .DW(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_rd      (in_rd),
      .in_rs1     (in_rs1),
      .in_rs2     (in_rs2),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_f      (alu_f),
      .alu_result (alu_result),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_rd     (out_rd),
      .dbg_addr   (dbg_addr),
      .dbg_data   (dbg_data)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Model: an accepted instruction's result is fixed at accept time from the
   // architectural register values; it is presented two cycles later until taken.
   initial begin : compare
      bit          front_rdy;
      bit          exp_rdy;
      ent_t        e;
      logic [31:0] a, b;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            mq.delete();
            for (int i = 0; i < 8; i++) mregs[i] = 32'd0;
         end else begin
            front_rdy = (mq.size() > 0) && (cyc >= mq[0].acc + 2);
            exp_rdy   = (mq.size() == 0) || (B2B && front_rdy && out_ready);
            chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
            chk("out_valid", {31'd0, out_valid}, {31'd0, front_rdy});
            if (front_rdy) begin
               chk("out_data", out_data, mq[0].data);
               chk("out_rd", {29'd0, out_rd}, {29'd0, mq[0].rd});
            end
            if (out_valid && out_ready && front_rdy) begin
               e     = mq.pop_front();
               e.cyc = cyc;
               seen.push_back(e);
            end
            if (in_valid && in_ready) begin
               a      = mregs[in_rs1];
               b      = mregs[in_rs2];
               e.data = alu_ref(in_op, a, b);
               e.rd   = in_rd;
               e.acc  = cyc;
               e.cyc  = 0;
               mq.push_back(e);
               if (in_rd != 3'd0) mregs[in_rd] = e.data;
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic issue(input logic [2:0] op, input logic [2:0] rd,
                        input logic [2:0] rs1, input logic [2:0] rs2);
      bit got;
      in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_valid = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 50 && !got; k++) begin
         @(negedge clk);
         if (in_ready) got = 1'b1;
      end
      if (!got) chk("issue_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      for (int k = 0; k < 50 && !done; k++) begin
         @(posedge clk);
         if (mq.size() == 0 && !out_valid) done = 1'b1;
      end
      if (!done) chk("drain_timeout", 32'd0, 32'd1);
      #1;
   endtask

   task automatic dbg_check(input logic [2:0] addr, input logic [31:0] exp);
      dbg_addr = addr;
      @(negedge clk);
      chk("dbg_data", dbg_data, exp);
      @(posedge clk); #1;
   endtask

   task automatic seen_check(input int idx, input logic [31:0] d, input logic [2:0] rd);
      if (idx >= seen.size()) begin
         chk("seen_missing", seen.size(), idx + 1);
      end else begin
         chk("res_data", seen[idx].data, d);
         chk("res_rd", {29'd0, seen[idx].rd}, {29'd0, rd});
      end
   endtask

   initial begin : drive
      bit got;
      reset = 1'b1; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
      out_ready = 1'b0; dbg_addr = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_rd", {29'd0, out_rd}, 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_b", alu_b, 32'd0);
      chk("rst_alu_f", {29'd0, alu_f}, 32'd0);
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) dbg_check(i[2:0], 32'd0);

      // Seed r1 with four dependent incs, then r2 = r1 + r1
      out_ready = 1'b1;
      repeat (4) issue(3'b001, 3'd1, 3'd1, 3'd0);
      issue(3'b000, 3'd2, 3'd1, 3'd1);
      in_valid = 1'b0;
      drain();
      seen_check(0, 32'd1, 3'd1);
      seen_check(1, 32'd2, 3'd1);
      seen_check(2, 32'd3, 3'd1);
      seen_check(3, 32'd4, 3'd1);
      seen_check(4, 32'd8, 3'd2);
      if (seen.size() > 4) chk("latency", seen[4].cyc - seen[4].acc, 32'd2);

      // Wrap-around, mul, write to r0
      issue(3'b011, 3'd3, 3'd0, 3'd0);
      issue(3'b001, 3'd4, 3'd3, 3'd0);
      issue(3'b100, 3'd5, 3'd2, 3'd2);
      issue(3'b001, 3'd0, 3'd0, 3'd0);
      in_valid = 1'b0;
      drain();
      seen_check(5, 32'hFFFF_FFFF, 3'd3);
      seen_check(6, 32'd0, 3'd4);
      seen_check(7, 32'd64, 3'd5);
      seen_check(8, 32'd1, 3'd0);
      dbg_check(3'd0, 32'd0);
      dbg_check(3'd3, 32'hFFFF_FFFF);
      dbg_check(3'd5, 32'd64);

      // Backpressure in WB with a pending instruction held upstream
      out_ready = 1'b0;
      issue(3'b000, 3'd6, 3'd5, 3'd1);
      in_op = 3'b010; in_rd = 3'd7; in_rs1 = 3'd6; in_rs2 = 3'd1; in_valid = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         if (out_valid) got = 1'b1;
      end
      if (!got) chk("wb_timeout", 32'd0, 32'd1);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         chk("hold_valid", {31'd0, out_valid}, 32'd1);
         chk("hold_data", out_data, 32'd68);
         chk("hold_rd", {29'd0, out_rd}, 32'd6);
         chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      issue(3'b010, 3'd7, 3'd6, 3'd1);
      in_valid = 1'b0;
      drain();
      seen_check(9, 32'd68, 3'd6);
      seen_check(10, 32'd64, 3'd7);
      dbg_check(3'd7, 32'd64);

      // Reset while the instruction is in EXEC: nothing may be written back
      issue(3'b001, 3'd7, 3'd7, 3'd0);
      in_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_exec_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_exec_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      dbg_check(3'd7, 32'd0);
      dbg_check(3'd1, 32'd0);

      // Streaming dependent incs: spacing depends on back-to-back support
      seen.delete();
      repeat (4) issue(3'b001, 3'd1, 3'd1, 3'd0);
      in_valid = 1'b0;
      drain();
      for (int i = 0; i < 4; i++) seen_check(i, i + 1, 3'd1);
      for (int i = 1; i < 4 && i < seen.size(); i++)
         chk("stream_spacing", seen[i].cyc - seen[i-1].cyc, SPACING);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

endmodule
`default_nettype wire
